// File: rtl/label_pack_pkg.sv
// -----------------------------------------------------------------------------
// label_pack_pkg : geometry and FSM state type shared with the labeling engine.
// Revision: 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

package label_pack_pkg;

  localparam int IMG_W        = 32;
  localparam int IMG_H        = 32;
  localparam int PIX_PER_BYTE = 8;
  localparam int PACK_DEPTH   = 128;
  localparam int SRAM_AW      = 10;
  localparam int PACK_AW      = 7;
  localparam int NPIX         = IMG_W * IMG_H;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/label_pack_shreg.sv
// -----------------------------------------------------------------------------
// label_pack_shreg : MSB-first 8-bit packer with bit counter; strobes on 8th bit.
// Revision: 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module label_pack_shreg
  import label_pack_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic                    i_bit,
  output logic                    o_byte_vld,
  output logic [PIX_PER_BYTE-1:0] o_byte
);

  localparam int CW = $clog2(PIX_PER_BYTE);
  localparam logic [CW-1:0] c_last = CW'(PIX_PER_BYTE - 1);

  logic [PIX_PER_BYTE-2:0] r_sh;
  logic [CW-1:0]           r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_sh  <= {r_sh[PIX_PER_BYTE-3:0], i_bit};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The completed byte is the seven held bits plus the bit arriving now.
  assign o_byte     = {r_sh, i_bit};
  assign o_byte_vld = i_en && (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/label_pack.sv
// -----------------------------------------------------------------------------
// label_pack : reads the 32x32 label SRAM and writes a 128-byte binary pack map.
// Optional statistics (fg_count, max_label) under macro LABEL_STAT_EN.
// Revision: 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module label_pack
  import label_pack_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  output logic [SRAM_AW-1:0] o_sram_a,
  input  logic [7:0]         i_sram_q,
  output logic [PACK_AW-1:0] o_pack_a,
  output logic [7:0]         o_pack_d,
  output logic               o_pack_wen,
  output logic               o_busy,
`ifdef LABEL_STAT_EN
  output logic [10:0]        o_fg_count,
  output logic [7:0]         o_max_label,
`endif
  output logic               o_finish
);

  localparam logic [SRAM_AW-1:0] c_last_addr = SRAM_AW'(NPIX - 1);

  state_t             r_state;
  logic [SRAM_AW-1:0] r_sram_a;
  logic               r_dvld;
  logic               r_drain;
  logic [PACK_AW-1:0] r_k;
  logic [PACK_AW-1:0] r_pack_a;
  logic [7:0]         r_pack_d;
  logic               r_pack_wen;
  logic               r_busy;
  logic               r_finish;

  logic               w_start_acc;
  logic               w_bit;
  logic               w_byte_vld;
  logic [7:0]         w_byte;

  assign w_start_acc = (r_state == IDLE) && i_start;
  assign w_bit       = (i_sram_q != 8'd0);

  label_pack_shreg u_shreg (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_start_acc),
    .i_en       (r_dvld),
    .i_bit      (w_bit),
    .o_byte_vld (w_byte_vld),
    .o_byte     (w_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_sram_a   <= '0;
      r_dvld     <= 1'b0;
      r_drain    <= 1'b0;
      r_k        <= '0;
      r_pack_a   <= '0;
      r_pack_d   <= '0;
      r_pack_wen <= 1'b1;
      r_busy     <= 1'b0;
      r_finish   <= 1'b0;
    end else begin
      // SRAM data for an address issued in RUN arrives one cycle later.
      r_dvld   <= (r_state == RUN);
      r_finish <= 1'b0;

      if (w_byte_vld) begin
        r_pack_wen <= 1'b0;
        r_pack_a   <= r_k;
        r_pack_d   <= w_byte;
        r_k        <= r_k + 1'b1;
      end else begin
        r_pack_wen <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state  <= RUN;
            r_sram_a <= '0;
            r_busy   <= 1'b1;
            r_k      <= '0;
            r_drain  <= 1'b0;
          end
        end
        RUN: begin
          if (r_sram_a == c_last_addr) r_state <= DRAIN;
          else                         r_sram_a <= r_sram_a + 1'b1;
        end
        DRAIN: begin
          if (r_drain) begin
            r_state  <= DONE;
            r_finish <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_drain  <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef LABEL_STAT_EN
  logic [10:0] r_fg_count;
  logic [7:0]  r_max_label;

  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      r_fg_count  <= '0;
      r_max_label <= '0;
    end else if (r_dvld) begin
      r_fg_count <= r_fg_count + {10'd0, w_bit};
      if (i_sram_q > r_max_label) r_max_label <= i_sram_q;
    end
  end

  assign o_fg_count  = r_fg_count;
  assign o_max_label = r_max_label;
`endif

  assign o_sram_a   = r_sram_a;
  assign o_pack_a   = r_pack_a;
  assign o_pack_d   = r_pack_d;
  assign o_pack_wen = r_pack_wen;
  assign o_busy     = r_busy;
  assign o_finish   = r_finish;

endmodule

`default_nettype wire

// File: tb/tb_label_pack.sv
// -----------------------------------------------------------------------------
// tb_label_pack : directed scoreboard bench for label_pack (stats under LABEL_STAT_EN).
// Revision: 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_label_pack;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] sram_a;
  logic [7:0] sram_q;
  logic [6:0] pack_a;
  logic [7:0] pack_d;
  logic       pack_wen;
  logic       busy;
  logic       finish;
`ifdef LABEL_STAT_EN
  logic [10:0] fg_count;
  logic [7:0]  max_label;
`endif

  label_pack dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (start),
    .o_sram_a   (sram_a),
    .i_sram_q   (sram_q),
    .o_pack_a   (pack_a),
    .o_pack_d   (pack_d),
    .o_pack_wen (pack_wen),
    .o_busy     (busy),
`ifdef LABEL_STAT_EN
    .o_fg_count (fg_count),
    .o_max_label(max_label),
`endif
    .o_finish   (finish)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  always @(posedge clk) sram_q <= mem[sram_a];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         t;
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t sb[$];

  // Every observed write must match the oldest expected write exactly.
  always @(negedge clk) begin
    if (pack_wen === 1'b0) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed a=%0d d=%02h cyc=%0d required no write", pack_a, pack_d, cyc);
      end
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        checks++;
        assert (pack_a === e.a && pack_d === e.d && cyc == e.t) else begin
          errors++;
          $error("FAIL write observed a=%0d d=%02h cyc=%0d required a=%0d d=%02h cyc=%0d",
                 pack_a, pack_d, cyc, e.a, e.d, e.t);
        end
      end
    end
  end

  function automatic logic [7:0] model_byte(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = (mem[8*k+i] != 8'd0);
    return b;
  endfunction

  function automatic int model_fg();
    int n = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != 8'd0) n++;
    return n;
  endfunction

  function automatic int model_max();
    int m = 0;
    for (int i = 0; i < 1024; i++) if (int'(mem[i]) > m) m = int'(mem[i]);
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pass(input int t0, input int nbytes);
    for (int k = 0; k < nbytes; k++) sb.push_back('{t0 + 8*k + 10, 7'(k), model_byte(k)});
  endtask

  // Returns on the negedge of cycle t0+1027 (or after the time-out bound).
  task automatic wait_pass(input string tag, input int t0, input bit hold, input int remain);
    bit got = 1'b0;
    int berr = 0;
    int rel;
    for (int i = 0; i < 1200 && !got; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      rel = cyc - t0;
      if (busy !== ((rel >= 1) && (rel <= 1026))) berr++;
      if (finish === 1'b1) got = 1'b1;
    end
    check({tag, "_finish_cycle"}, cyc - t0, 1027);
    check({tag, "_busy_window"}, berr, 0);
    check({tag, "_all_writes"}, sb.size(), remain);
`ifdef LABEL_STAT_EN
    check({tag, "_fg_count"}, {21'd0, fg_count}, model_fg());
    check({tag, "_max_label"}, {24'd0, max_label}, model_max());
`endif
  endtask

  task automatic run_pass(input string tag);
    int t0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    push_pass(t0, 128);
    wait_pass(tag, t0, 1'b0, 0);
    @(negedge clk);
    check({tag, "_finish_pulse"}, finish, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_sram_a", sram_a, 0);
    check("rst_pack_a", pack_a, 0);
    check("rst_pack_d", pack_d, 0);
    check("rst_pack_wen", pack_wen, 1);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
`ifdef LABEL_STAT_EN
    check("rst_fg_count", fg_count, 0);
    check("rst_max_label", max_label, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    run_pass("zero");

    mem[0] = 8'd5;
    run_pass("first");

    mem[0] = 8'd0;
    mem[1023] = 8'hFF;
    mem[8] = 8'd1;
    run_pass("corners");

    for (int i = 0; i < 1024; i++) mem[i] = (i % 2 == 0) ? 8'd3 : 8'd0;
    run_pass("even");

    // Reset in cycle 500 of a pass: only writes before it survive.
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 3));
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    push_pass(t0, 62);
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 500) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_pack_wen", pack_wen, 1);
    check("midrst_busy", busy, 0);
    check("midrst_sram_a", sram_a, 0);
    check("midrst_writes_before", sb.size(), 0);
    repeat (600) @(negedge clk);
    check("midrst_idle_busy", busy, 0);
    run_pass("after_rst");

    // Start held high: back-to-back passes, the second accepted right after finish.
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    push_pass(t0, 128);
    push_pass(t0 + 1028, 128);
    wait_pass("hold_a", t0, 1'b1, 128);
    @(negedge clk);
    check("hold_finish_pulse", finish, 1'b0);
    wait_pass("hold_b", t0 + 1028, 1'b1, 0);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("hold_no_third", busy, 0);
    check("hold_no_extra", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
